// File: rtl/uart_rx_reg_bank.sv
// ============================================================================
// Module   : uart_rx_reg_bank
// Purpose  : Builds UART bytes into an addressed register bank. Each frame is
//            a start address followed by REG_WIDTH/8 bytes per register, and
//            the address auto-increments from one register to the next.
// Options  : UART_RX_REG_TIMEOUT_EN (abort a frame after an idle gap)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_reg_bank #(
    parameter int REG_WIDTH      = 32,
    parameter int REG_NUM        = 16,
    parameter int MSB_FIRST      = 1,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int ADDR_W        = $clog2(REG_NUM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [7:0]           rx_data,
    input  logic                 rx_ack,
    input  logic                 rx_frame_ack,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [REG_WIDTH-1:0] rd_data,
    output logic                 wr_valid,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [REG_WIDTH-1:0] wr_data,
    output logic                 frame_err
);

    localparam int BYTES = REG_WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(REG_NUM - 1);
    localparam logic [8:0]        NUM_9     = 9'(REG_NUM);
    localparam logic [ADDR_W:0]   NUM_A     = (ADDR_W + 1)'(REG_NUM);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      addr_ptr_q, addr_ptr_d;
    logic [CNT_W-1:0]       byte_cnt_q, byte_cnt_d;
    logic [REG_WIDTH-1:0]   shift_q, shift_d;
    logic [REG_WIDTH-1:0]   bank_q [REG_NUM];
    logic [REG_WIDTH-1:0]   bank_d [REG_NUM];
    logic [REG_WIDTH-1:0]   rd_data_q, rd_data_d;
    logic                   wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [REG_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                   frame_err_q, frame_err_d;
    logic [REG_WIDTH-1:0]   shift_in;
    logic                   timeout;

    // Value of the shift register once the current byte has been absorbed.
    generate
        if (REG_WIDTH == 8) begin : g_single_byte
            assign shift_in = rx_data;
        end else if (MSB_FIRST != 0) begin : g_msb_first
            assign shift_in = {shift_q[REG_WIDTH-9:0], rx_data};
        end else begin : g_lsb_first
            assign shift_in = {rx_data, shift_q[REG_WIDTH-1:8]};
        end
    endgenerate

`ifdef UART_RX_REG_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] idle_cnt_q, idle_cnt_d;

    always_comb begin
        idle_cnt_d = '0;
        timeout    = 1'b0;
        if ((state_q != IDLE) && !rx_ack) begin
            if (idle_cnt_q == TO_LAST) begin
                timeout = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + TO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        addr_ptr_d  = addr_ptr_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        bank_d      = bank_q;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_ack) begin
                    byte_cnt_d = '0;
                    shift_d    = '0;
                    if ({1'b0, rx_data} < NUM_9) begin
                        addr_ptr_d = rx_data[ADDR_W-1:0];
                        state_d    = rx_frame_ack ? IDLE : DATA;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = rx_frame_ack ? IDLE : DROP;
                    end
                end
            end
            DATA: begin
                if (rx_ack) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        bank_d[addr_ptr_q] = shift_in;
                        wr_valid_d         = 1'b1;
                        wr_addr_d          = addr_ptr_q;
                        wr_data_d          = shift_in;
                        byte_cnt_d         = '0;
                        shift_d            = '0;
                        addr_ptr_d         = (addr_ptr_q == LAST_ADDR) ? '0
                                           : addr_ptr_q + ADDR_W'(1);
                    end else begin
                        shift_d    = shift_in;
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end
                // Frame end is judged on the counter after this cycle's byte.
                if (rx_frame_ack || timeout) begin
                    frame_err_d = (byte_cnt_d != '0);
                    byte_cnt_d  = '0;
                    shift_d     = '0;
                    state_d     = IDLE;
                end
            end
            DROP: begin
                if (rx_frame_ack || timeout) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Out-of-range read addresses (non power-of-two banks) return zero.
    always_comb begin
        rd_data_d = '0;
        if ({1'b0, rd_addr} < NUM_A) begin
            rd_data_d = bank_q[rd_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_ptr_q  <= '0;
            byte_cnt_q  <= '0;
            shift_q     <= '0;
            for (int i = 0; i < REG_NUM; i++) begin
                bank_q[i] <= '0;
            end
            rd_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_ptr_q  <= addr_ptr_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            bank_q      <= bank_d;
            rd_data_q   <= rd_data_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign rd_data   = rd_data_q;
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign frame_err = frame_err_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_reg_bank.sv
// ============================================================================
// Module   : tb_uart_rx_reg_bank
// Purpose  : Directed self-checking bench for uart_rx_reg_bank (MSB-first and
//            LSB-first instances driven in parallel).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_reg_bank;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_ack;
    logic        rx_frame_ack;
    logic [3:0]  rd_addr;

    logic [31:0] rd_data_m, wr_data_m, rd_data_l, wr_data_l;
    logic [3:0]  wr_addr_m, wr_addr_l;
    logic        wr_valid_m, wr_valid_l, frame_err_m, frame_err_l;

    int checks;
    int errors;
    int err_seen;
    logic [3:0]  log_addr [$];
    logic [31:0] log_data [$];

    uart_rx_reg_bank #(
        .REG_WIDTH(32), .REG_NUM(16), .MSB_FIRST(1), .TIMEOUT_CYCLES(50)
    ) u_msb (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ack(rx_ack),
        .rx_frame_ack(rx_frame_ack), .rd_addr(rd_addr), .rd_data(rd_data_m),
        .wr_valid(wr_valid_m), .wr_addr(wr_addr_m), .wr_data(wr_data_m),
        .frame_err(frame_err_m)
    );

    uart_rx_reg_bank #(
        .REG_WIDTH(32), .REG_NUM(16), .MSB_FIRST(0), .TIMEOUT_CYCLES(50)
    ) u_lsb (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ack(rx_ack),
        .rx_frame_ack(rx_frame_ack), .rd_addr(rd_addr), .rd_data(rd_data_l),
        .wr_valid(wr_valid_l), .wr_addr(wr_addr_l), .wr_data(wr_data_l),
        .frame_err(frame_err_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write pulse and frame error of the MSB-first instance.
    always @(negedge clk) begin
        if (wr_valid_m) begin
            log_addr.push_back(wr_addr_m);
            log_data.push_back(wr_data_m);
        end
        if (frame_err_m) err_seen++;
    end

    // Present one cycle of inputs starting at a falling edge.
    task automatic drive(input logic [7:0] b, input logic a, input logic fa);
        rx_data      = b;
        rx_ack       = a;
        rx_frame_ack = fa;
        @(negedge clk);
        rx_ack       = 1'b0;
        rx_frame_ack = 1'b0;
    endtask

    task automatic test_reset;
        checks++;
        if (rd_data_m !== 32'h0) begin
            errors++; $display("FAIL reset_rd_data got %h want %h", rd_data_m, 32'h0);
        end
        checks++;
        if (wr_valid_m !== 1'b0 || wr_valid_l !== 1'b0) begin
            errors++; $display("FAIL reset_wr_valid got %b/%b want 0", wr_valid_m, wr_valid_l);
        end
        checks++;
        if (wr_addr_m !== 4'h0) begin
            errors++; $display("FAIL reset_wr_addr got %h want 0", wr_addr_m);
        end
        checks++;
        if (wr_data_m !== 32'h0) begin
            errors++; $display("FAIL reset_wr_data got %h want 0", wr_data_m);
        end
        checks++;
        if (frame_err_m !== 1'b0 || frame_err_l !== 1'b0) begin
            errors++; $display("FAIL reset_frame_err got %b/%b want 0", frame_err_m, frame_err_l);
        end
    endtask

    task automatic test_single_msb_lsb;
        int w0, e0;
        w0 = log_addr.size();
        e0 = err_seen;
        drive(8'h03, 1, 0);
        drive(8'hDE, 1, 0);
        drive(8'hAD, 1, 0);
        drive(8'hBE, 1, 0);
        drive(8'hEF, 1, 0);
        checks++;
        if (wr_valid_m !== 1'b1 || wr_valid_l !== 1'b1) begin
            errors++; $display("FAIL single_latency got %b/%b want 1", wr_valid_m, wr_valid_l);
        end
        checks++;
        if (wr_addr_m !== 4'd3 || wr_addr_l !== 4'd3) begin
            errors++; $display("FAIL single_addr got %h/%h want 3", wr_addr_m, wr_addr_l);
        end
        checks++;
        if (wr_data_m !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_msb_data got %h want DEADBEEF", wr_data_m);
        end
        checks++;
        if (wr_data_l !== 32'hEFBEADDE) begin
            errors++; $display("FAIL single_lsb_data got %h want EFBEADDE", wr_data_l);
        end
        drive(8'h00, 0, 1);
        checks++;
        if (wr_valid_m !== 1'b0 || wr_data_m !== 32'hDEADBEEF) begin
            errors++; $display("FAIL single_hold got v=%b d=%h want v=0 d=DEADBEEF", wr_valid_m, wr_data_m);
        end
        rd_addr = 4'd3;
        drive(8'h00, 0, 0);
        checks++;
        if (rd_data_m !== 32'hDEADBEEF || rd_data_l !== 32'hEFBEADDE) begin
            errors++; $display("FAIL single_read got %h/%h want DEADBEEF/EFBEADDE", rd_data_m, rd_data_l);
        end
        checks++;
        if (log_addr.size() - w0 != 1 || err_seen != e0 || frame_err_l !== 1'b0) begin
            errors++; $display("FAIL single_counts got writes=%0d errs=%0d want 1/0",
                               log_addr.size() - w0, err_seen - e0);
        end
    endtask

    task automatic test_wrap;
        int w0;
        w0 = log_addr.size();
        drive(8'h0F, 1, 0);
        for (int i = 0; i < 8; i++) drive(8'h11 + 8'(i), 1, 0);
        drive(8'h00, 0, 1);
        checks++;
        if (log_addr.size() - w0 != 2) begin
            errors++; $display("FAIL wrap_count got %0d want 2", log_addr.size() - w0);
        end else begin
            checks++;
            if (log_addr[w0] !== 4'd15 || log_data[w0] !== 32'h11121314) begin
                errors++; $display("FAIL wrap_first got %h:%h want f:11121314", log_addr[w0], log_data[w0]);
            end
            checks++;
            if (log_addr[w0+1] !== 4'd0 || log_data[w0+1] !== 32'h15161718) begin
                errors++; $display("FAIL wrap_second got %h:%h want 0:15161718", log_addr[w0+1], log_data[w0+1]);
            end
        end
        rd_addr = 4'd0;
        drive(8'h00, 0, 0);
        checks++;
        if (rd_data_m !== 32'h15161718) begin
            errors++; $display("FAIL wrap_read0 got %h want 15161718", rd_data_m);
        end
    endtask

    task automatic test_partial_and_bad_addr;
        int w0, e0;
        w0 = log_addr.size();
        e0 = err_seen;
        drive(8'h02, 1, 0);
        drive(8'hAA, 1, 0);
        drive(8'hBB, 1, 0);
        drive(8'h00, 0, 1);
        checks++;
        if (frame_err_m !== 1'b1) begin
            errors++; $display("FAIL partial_err got %b want 1", frame_err_m);
        end
        rd_addr = 4'd2;
        drive(8'h00, 0, 0);
        checks++;
        if (rd_data_m !== 32'h0 || log_addr.size() != w0 || err_seen - e0 != 1) begin
            errors++; $display("FAIL partial_discard got rd=%h writes=%0d errs=%0d want 0/0/1",
                               rd_data_m, log_addr.size() - w0, err_seen - e0);
        end
        drive(8'h20, 1, 0);
        checks++;
        if (frame_err_m !== 1'b1) begin
            errors++; $display("FAIL badaddr_err got %b want 1", frame_err_m);
        end
        for (int i = 0; i < 4; i++) drive(8'h01 + 8'(i), 1, 0);
        drive(8'h00, 0, 1);
        rd_addr = 4'd0;
        drive(8'h00, 0, 0);
        checks++;
        if (log_addr.size() != w0 || err_seen - e0 != 2 || rd_data_m !== 32'h15161718) begin
            errors++; $display("FAIL badaddr_drop got writes=%0d errs=%0d rd0=%h want 0/2/15161718",
                               log_addr.size() - w0, err_seen - e0, rd_data_m);
        end
    endtask

    task automatic test_simultaneous;
        int w0, e0;
        w0 = log_addr.size();
        e0 = err_seen;
        rd_addr = 4'd4;
        drive(8'h04, 1, 0);
        drive(8'h01, 1, 0);
        drive(8'h02, 1, 0);
        drive(8'h03, 1, 0);
        drive(8'h04, 1, 1);
        checks++;
        if (wr_valid_m !== 1'b1 || wr_data_m !== 32'h01020304 || rd_data_m !== 32'h0) begin
            errors++; $display("FAIL simul_write got v=%b d=%h rd_old=%h want 1/01020304/0",
                               wr_valid_m, wr_data_m, rd_data_m);
        end
        drive(8'h00, 0, 0);
        checks++;
        if (rd_data_m !== 32'h01020304) begin
            errors++; $display("FAIL simul_read_new got %h want 01020304", rd_data_m);
        end
        drive(8'h07, 1, 1);
        drive(8'h06, 1, 0);
        drive(8'hA1, 1, 0);
        drive(8'hA2, 1, 0);
        drive(8'hA3, 1, 0);
        drive(8'hA4, 1, 1);
        drive(8'h00, 0, 0);
        checks++;
        if (log_addr.size() - w0 != 2 || err_seen != e0) begin
            errors++; $display("FAIL simul_counts got writes=%0d errs=%0d want 2/0",
                               log_addr.size() - w0, err_seen - e0);
        end else begin
            checks++;
            if (log_addr[w0+1] !== 4'd6 || log_data[w0+1] !== 32'hA1A2A3A4) begin
                errors++; $display("FAIL simul_idle_addr got %h:%h want 6:A1A2A3A4",
                                   log_addr[w0+1], log_data[w0+1]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int w0;
        w0 = log_addr.size();
        drive(8'h08, 1, 0);
        drive(8'h55, 1, 0);
        drive(8'h66, 1, 0);
        rst_n = 1'b0;
        drive(8'h00, 0, 0);
        drive(8'h00, 0, 0);
        checks++;
        if (wr_valid_m !== 1'b0 || rd_data_m !== 32'h0 || wr_data_m !== 32'h0) begin
            errors++; $display("FAIL midrst_outputs got v=%b rd=%h wd=%h want 0/0/0",
                               wr_valid_m, rd_data_m, wr_data_m);
        end
        rst_n = 1'b1;
        drive(8'h00, 0, 0);
        drive(8'h09, 1, 0);
        drive(8'hC0, 1, 0);
        drive(8'hC1, 1, 0);
        drive(8'hC2, 1, 0);
        drive(8'hC3, 1, 0);
        drive(8'h00, 0, 1);
        rd_addr = 4'd3;
        drive(8'h00, 0, 0);
        checks++;
        if (log_addr.size() - w0 != 1) begin
            errors++; $display("FAIL midrst_count got %0d want 1", log_addr.size() - w0);
        end else begin
            checks++;
            if (log_addr[w0] !== 4'd9 || log_data[w0] !== 32'hC0C1C2C3) begin
                errors++; $display("FAIL midrst_write got %h:%h want 9:C0C1C2C3", log_addr[w0], log_data[w0]);
            end
        end
        checks++;
        if (rd_data_m !== 32'h0) begin
            errors++; $display("FAIL midrst_bank_clear got %h want 0", rd_data_m);
        end
    endtask

`ifdef UART_RX_REG_TIMEOUT_EN
    task automatic test_timeout;
        int w0, e0, hit;
        w0  = log_addr.size();
        e0  = err_seen;
        hit = 0;
        drive(8'h01, 1, 0);
        drive(8'hAA, 1, 0);
        for (int i = 1; i <= 60; i++) begin
            drive(8'h00, 0, 0);
            if (frame_err_m === 1'b1 && hit == 0) hit = i;
        end
        checks++;
        if (hit != 50) begin
            errors++; $display("FAIL timeout_cycle got %0d want 50", hit);
        end
        drive(8'h05, 1, 0);
        for (int i = 0; i < 4; i++) drive(8'h01 + 8'(i), 1, 0);
        drive(8'h00, 0, 1);
        checks++;
        if (log_addr.size() - w0 != 1 || err_seen - e0 != 1) begin
            errors++; $display("FAIL timeout_counts got writes=%0d errs=%0d want 1/1",
                               log_addr.size() - w0, err_seen - e0);
        end else begin
            checks++;
            if (log_addr[w0] !== 4'd5 || log_data[w0] !== 32'h01020304) begin
                errors++; $display("FAIL timeout_next got %h:%h want 5:01020304", log_addr[w0], log_data[w0]);
            end
        end
    endtask
`endif

    initial begin
        checks       = 0;
        errors       = 0;
        err_seen     = 0;
        rst_n        = 1'b0;
        rx_data      = 8'h00;
        rx_ack       = 1'b0;
        rx_frame_ack = 1'b0;
        rd_addr      = 4'd0;
        @(negedge clk);
        @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        @(negedge clk);
        test_single_msb_lsb;
        test_wrap;
        test_partial_and_bad_addr;
        test_simultaneous;
        test_reset_mid_frame;
`ifdef UART_RX_REG_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_rx_reg_bank.md
Name: uart_rx_reg_bank

Overview:
- Assembles UART receive bytes into a bank of REG_NUM registers, each REG_WIDTH bits wide, and adds addressed, auto-incrementing multi-register writes.
- Frame format: the first byte is the start register address, followed by REG_WIDTH/8 bytes per register.
- Sits between the UART byte receiver and the configuration/control logic.
- Provides a one-cycle write strobe per completed register and a registered read port.

Parameters:
- REG_WIDTH, 32, register width in bits; must be a multiple of 8, range 8..128.
- REG_NUM, 16, number of registers in the bank, range 2..256; ADDR_W = clog2(REG_NUM) is a localparam.
- MSB_FIRST, 1, 1 = first data byte lands in bits [REG_WIDTH-1:REG_WIDTH-8]; 0 = first data byte lands in bits [7:0].
- TIMEOUT_CYCLES, 100000, idle-gap limit in clk cycles; used only with UART_RX_REG_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  received byte, valid while rx_ack=1
- rx_ack  in  1  one-cycle byte strobe
- rx_frame_ack  in  1  one-cycle end-of-frame strobe
- rd_addr  in  ADDR_W  bank read address
- rd_data  out  REG_WIDTH  bank contents at rd_addr, 1-cycle latency
- wr_valid  out  1  one-cycle pulse: a register was written
- wr_addr  out  ADDR_W  register index of the current write
- wr_data  out  REG_WIDTH  value written
- frame_err  out  1  one-cycle pulse: frame error (see below)

Behaviour:
- Reset (async, rst_n=0): all bank registers = 0, FSM = IDLE, byte counter = 0, shift register = 0. rd_data, wr_valid, wr_addr, wr_data and frame_err all = 0. A reset mid-frame discards the partial frame; no wr_valid is issued.
- FSM states:
  - IDLE: on rx_ack, if rx_data < REG_NUM, load addr_ptr = rx_data and go to DATA; otherwise pulse frame_err and go to DROP.
  - DATA: each rx_ack shifts in one byte (order per MSB_FIRST) and increments the byte counter.
    - On byte REG_WIDTH/8, the register is complete: next cycle, bank[addr_ptr] is written, wr_valid=1, wr_addr=addr_ptr, wr_data=assembled value.
    - The byte counter then clears and addr_ptr increments modulo REG_NUM (REG_NUM-1 wraps to 0).
    - rx_frame_ack with byte counter = 0 → IDLE, no error.
    - rx_frame_ack with byte counter ≠ 0 → partial register discarded (bank unchanged), frame_err pulse, IDLE.
  - DROP: ignore all bytes; rx_frame_ack → IDLE.
- Simultaneous rx_ack and rx_frame_ack: the byte is processed first, then the frame end is evaluated on the updated counter.
  - In DATA, if that byte completes a register, the write occurs and there is no error.
  - In IDLE, the byte is treated as an address-only frame: no write, no error, stay in IDLE.
- Latency: last data byte strobe → wr_valid is exactly 1 cycle. A bank write and a read of the same address in the same cycle return the old value; the new value appears on the next read.
- wr_data and wr_addr hold their last value between pulses. frame_err is a single-cycle pulse.
- Bytes arriving faster than REG_WIDTH/8 cycles apart are accepted; back-to-back rx_ack on consecutive cycles is supported.

Optional Feature:
- Macro: UART_RX_REG_TIMEOUT_EN.
- Defined: an idle counter runs while the FSM is in DATA or DROP, and clears on every rx_ack. If it reaches TIMEOUT_CYCLES:
  - a partial register (byte counter ≠ 0) is discarded and frame_err pulses;
  - with byte counter = 0, no error is flagged;
  - FSM → IDLE in either case.
- Undefined: no counter is present, and the FSM leaves DATA/DROP only on rx_frame_ack.

Test Plan:
- Frame 0x03,DE,AD,BE,EF then rx_frame_ack, MSB_FIRST=1 → one wr_valid, wr_addr=3, wr_data=0xDEADBEEF; rd_addr=3 gives rd_data=0xDEADBEEF next cycle; frame_err never asserts.
- Same bytes with MSB_FIRST=0 → wr_data=0xEFBEADDE.
- Frame 0x0F followed by 8 data bytes 11..18 (REG_NUM=16) → writes bank[15]=0x11121314, then bank[0]=0x15161718 (address wrap); 2 wr_valid pulses.
- Frame 0x02,AA,BB then rx_frame_ack → no wr_valid, frame_err pulse, bank[2] unchanged. Frame 0x20 (≥REG_NUM) then 4 bytes → frame_err, bytes ignored, no write.
- rx_ack with the 4th data byte in the same cycle as rx_frame_ack → write completes, no frame_err. Assert rst_n=0 after 2 data bytes, release, send a full frame → only the new frame's write occurs.
- With UART_RX_REG_TIMEOUT_EN, TIMEOUT_CYCLES=50: send 0x01,AA, then idle 60 cycles → frame_err at cycle 50 of the gap; the next byte 0x05 is treated as an address.
